fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter BOOT_ADDR, 32'h0000_0000, PC value loaded on reset; SHALL be word-aligned.
REQ-002 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_B_J_result  input  1  redirect request from branch/jump control; 1 = taken branch or jump.
REQ-005 i_target  input  32  redirect target PC, sampled when i_B_J_result=1.
REQ-006 o_imem_req  output  1  instruction memory request.
REQ-007 o_imem_addr  output  32  request address, valid while o_imem_req=1.
REQ-008 i_imem_gnt  input  1  memory accepts request this cycle.
REQ-009 i_imem_rvalid  input  1  read data valid.
REQ-010 i_imem_rdata  input  32  instruction word.
REQ-011 o_if_valid  output  1  decode-side entry available.
REQ-012 o_if_instr  output  32  instruction at FIFO head.
REQ-013 o_if_pc  output  32  PC of o_if_instr.
REQ-014 i_id_ready  input  1  decode accepts entry; pop on o_if_valid & i_id_ready.
REQ-015 o_if_misaligned  output  1  head entry is a misaligned-target marker (see Configuration).

Function
REQ-016 SHALL hold at most one outstanding memory request and a 2-entry instruction FIFO of {pc, instr, misaligned}.
REQ-017 FSM states: REQ (o_imem_req=1, o_imem_addr=pc), WAIT (outstanding, req=0), FULL (req=0, FIFO full), ERR (req=0, halted).
REQ-018 REQ: on i_imem_gnt, latch req_pc<=pc, pc<=pc+4 (32-bit wrap at 32'hFFFF_FFFC -> 0), go WAIT.
REQ-019 WAIT: on i_imem_rvalid, push {req_pc, i_imem_rdata, 0} unless discard flag set; go REQ if post-cycle FIFO count <2, else FULL.
REQ-020 FULL: go REQ in the cycle after a pop leaves count <2.
REQ-021 o_if_valid SHALL equal FIFO non-empty; head fields SHALL be driven directly from FIFO storage (no added latency); push and pop in the same cycle SHALL keep count unchanged.
REQ-022 Redirect (i_B_J_result=1) SHALL take priority over push/pop: pc<=i_target, FIFO cleared, o_if_valid=0 next cycle.
REQ-023 Redirect in WAIT, or in REQ with i_imem_gnt same cycle: set discard flag, go/stay WAIT; the matching rvalid SHALL be dropped and clear the flag.
REQ-024 Redirect in REQ without gnt, in FULL, or in ERR: go REQ next cycle with o_imem_addr=i_target.
REQ-025 Redirect latency with zero-wait memory: redirect cycle N, request at N+1, gnt N+1, rvalid N+2, o_if_valid with o_if_pc=target at N+3.
REQ-026 A request once asserted SHALL keep o_imem_addr stable until gnt or redirect.

Reset
REQ-027 While i_rst_n=0 at a clock edge: pc=BOOT_ADDR, FIFO empty, discard=0, state=REQ; o_imem_req=0, o_if_valid=0, o_if_misaligned=0 during reset.
REQ-028 First cycle after release SHALL assert o_imem_req with o_imem_addr=BOOT_ADDR.
REQ-029 Reset mid-transaction SHALL abandon the outstanding request; a later rvalid with state REQ SHALL be ignored.

Configuration
REQ-030 Macro FETCH_MISALIGN_CHECK_EN defined: a redirect with i_target[1:0]!=0 SHALL issue no request, push {i_target, 32'h0000_0013, 1} into the cleared FIFO, go ERR; only a later redirect leaves ERR.
REQ-031 Macro undefined: i_target[1:0] SHALL be forced to 2'b00, ERR unreachable, o_if_misaligned tied 0; port list unchanged.

Structure
REQ-032 Shared package SHALL hold the fetch FSM state enum, the NOP constant 32'h0000_0013 and the FIFO entry struct.
REQ-033 FIFO SHALL be sub-module fetch_fifo (2 entries, push/pop/flush, count output).

Verification
REQ-034 Reset release, BOOT_ADDR=0, zero-wait memory, i_id_ready=1 -> o_if_pc sequence 0x0,0x4,0x8 on consecutive valid cycles from cycle 3.
REQ-035 i_id_ready=0 for 10 cycles -> exactly 2 entries held, o_imem_req=0 in FULL, no entry lost when ready returns.
REQ-036 Redirect to 0x100 while WAIT, rvalid next cycle with 0xDEADBEEF -> word dropped; first o_if_pc=0x100.
REQ-037 Redirect and pop in same cycle with 2 entries -> FIFO empty next cycle, no stale instr delivered.
REQ-038 FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> one entry pc=0x102, instr=0x13, o_if_misaligned=1, no o_imem_req until redirect to 0x200.
REQ-039 Reset asserted during WAIT, late rvalid -> ignored; next request address BOOT_ADDR.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg -- types and constants shared by the instruction fetch unit.
//   fetch_state_e : fetch FSM state encoding
//   NOP_INSTR     : instruction word inserted as a misaligned-target marker
//   fetch_entry_t : one instruction FIFO entry {pc, instr, misaligned}
//   FIFO_DEPTH    : instruction FIFO capacity
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_REQ,   // request driven to instruction memory
    ST_WAIT,  // one request outstanding, waiting for rvalid
    ST_FULL,  // FIFO full, no request until decode pops
    ST_ERR    // halted on misaligned redirect target
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- bundles the fetch unit's redirect, instruction-memory and
// decode-side handshake signals.
//   master : fetch unit side (drives o_*, receives i_*)
//   slave  : environment side (memory, branch control, decode)
interface fetch_unit_if;

  // redirect from branch/jump control
  logic        i_B_J_result;
  logic [31:0] i_target;
  // instruction memory
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  // decode side
  logic        o_if_valid;
  logic [31:0] o_if_instr;
  logic [31:0] o_if_pc;
  logic        i_id_ready;
  logic        o_if_misaligned;

  modport master (
    input  i_B_J_result, i_target,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
    input  i_id_ready,
    output o_imem_req, o_imem_addr,
    output o_if_valid, o_if_instr, o_if_pc, o_if_misaligned
  );

  modport slave (
    output i_B_J_result, i_target,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
    output i_id_ready,
    input  o_imem_req, o_imem_addr,
    input  o_if_valid, o_if_instr, o_if_pc, o_if_misaligned
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo -- 2-entry instruction FIFO for the fetch unit.
//   clk, rst_n  : clock, synchronous active-low reset
//   flush       : drop all entries; a simultaneous push lands as the only entry
//   push, wdata : write one entry (accepted when not full or when popping)
//   pop         : remove head entry (ignored when empty)
//   head, valid : head entry straight from storage, non-empty flag
//   count       : number of entries held (0..2)
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         valid,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [FIFO_DEPTH];
  fetch_entry_t mem_d [FIFO_DEPTH];
  logic         rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;

  logic pop_ok;
  logic push_ok;
  logic wr_ptr;

  assign pop_ok  = pop && (cnt_q != 2'd0);
  assign push_ok = push && ((cnt_q != 2'd2) || pop_ok);
  // With two slots the write slot is the head when empty or full (a full
  // FIFO only accepts a push together with a pop, reusing the freed head
  // slot), and the other slot when one entry is held.
  assign wr_ptr  = rd_q ^ cnt_q[0];

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = 1'b0;
      cnt_d = push ? 2'd1 : 2'd0;
      if (push) mem_d[0] = wdata;
    end else begin
      if (push_ok) mem_d[wr_ptr] = wdata;
      rd_d  = rd_q ^ pop_ok;
      cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      rd_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign valid = (cnt_q != 2'd0);
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage: one outstanding instruction-memory
// request, 2-entry instruction FIFO towards decode, branch/jump redirect.
//   BOOT_ADDR : word-aligned PC loaded on reset
//   i_clk     : clock
//   i_rst_n   : synchronous active-low reset
//   bus       : fetch_unit_if.master -- redirect (i_B_J_result/i_target),
//               memory (o_imem_req/o_imem_addr/i_imem_gnt/i_imem_rvalid/
//               i_imem_rdata), decode (o_if_valid/o_if_instr/o_if_pc/
//               i_id_ready/o_if_misaligned)
// Build option: define FETCH_MISALIGN_CHECK_EN to trap redirects to
// non-word-aligned targets (marker entry + halt in ST_ERR). Without it the
// target's low two bits are ignored and o_if_misaligned is always 0.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  fetch_unit_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         discard_q, discard_d;

  logic         fifo_flush;
  logic         fifo_push;
  logic         fifo_pop;
  fetch_entry_t push_entry;
  fetch_entry_t fifo_head;
  logic         fifo_valid;
  logic [1:0]   fifo_count;
  logic [1:0]   cnt_after;

  logic [31:0]  target_eff;
  logic         still_out;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic target_mis;
  assign target_mis = (bus.i_target[1:0] != 2'b00);
  assign target_eff = bus.i_target;
`else
  logic unused_target_lo;
  logic unused_head_mis;
  assign unused_target_lo = |bus.i_target[1:0];
  assign unused_head_mis  = fifo_head.misaligned;
  assign target_eff       = {bus.i_target[31:2], 2'b00};
`endif

  assign fifo_pop = bus.o_if_valid & bus.i_id_ready;

  // A memory response is still owed after this cycle when a request is
  // granted now, or when one was already owed and its rvalid is not here yet.
  assign still_out = ((state_q == ST_REQ) && bus.i_imem_gnt) ||
                     (((state_q == ST_WAIT) || discard_q) && !bus.i_imem_rvalid);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    fifo_flush = 1'b0;
    fifo_push  = 1'b0;
    push_entry = '{pc: req_pc_q, instr: bus.i_imem_rdata, misaligned: 1'b0};
    cnt_after  = fifo_count;

    // The response to an abandoned request is consumed wherever it lands.
    if (bus.i_imem_rvalid && discard_q) discard_d = 1'b0;

    if (bus.i_B_J_result) begin
      fifo_flush = 1'b1;
      pc_d       = target_eff;
      discard_d  = still_out;
      state_d    = still_out ? ST_WAIT : ST_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (target_mis) begin
        fifo_push  = 1'b1;
        push_entry = '{pc: bus.i_target, instr: NOP_INSTR, misaligned: 1'b1};
        state_d    = ST_ERR;
      end
`endif
    end else begin
      case (state_q)
        ST_REQ: begin
          if (bus.i_imem_gnt) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.i_imem_rvalid) begin
            fifo_push = !discard_q;
            cnt_after = fifo_count + {1'b0, !discard_q} - {1'b0, fifo_pop};
            state_d   = (cnt_after < 2'd2) ? ST_REQ : ST_FULL;
          end
        end
        ST_FULL: begin
          if (fifo_pop) state_d = ST_REQ;
        end
        ST_ERR: begin
          state_d = ST_ERR;
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_REQ;
      pc_q      <= BOOT_ADDR;
      req_pc_q  <= BOOT_ADDR;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      discard_q <= discard_d;
    end
  end

  fetch_fifo u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  // Reset gates the outputs so nothing is requested or presented while
  // i_rst_n is low, even before the first reset edge has cleared the state.
  assign bus.o_imem_req  = (state_q == ST_REQ) && i_rst_n;
  assign bus.o_imem_addr = pc_q;
  assign bus.o_if_valid  = fifo_valid && i_rst_n;
  assign bus.o_if_instr  = fifo_head.instr;
  assign bus.o_if_pc     = fifo_head.pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign bus.o_if_misaligned = fifo_valid && fifo_head.misaligned && i_rst_n;
`else
  assign bus.o_if_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  fetch_unit_if bus ();

  fetch_unit #(.BOOT_ADDR(32'h0000_0000)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Memory model: in auto mode grants every request and returns data the
  // next cycle (zero wait); otherwise the directed steps drive it by hand.
  logic        auto_mem;
  logic        gnt_man, rvalid_man;
  logic [31:0] rdata_man;
  logic        pend;
  logic [31:0] pend_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) begin
    if (!auto_mem || !rst_n) begin
      pend <= 1'b0;
    end else begin
      pend      <= bus.o_imem_req & bus.i_imem_gnt;
      pend_addr <= bus.o_imem_addr;
    end
  end

  assign bus.i_imem_gnt    = auto_mem ? bus.o_imem_req : gnt_man;
  assign bus.i_imem_rvalid = auto_mem ? pend : rvalid_man;
  assign bus.i_imem_rdata  = auto_mem ? instr_of(pend_addr) : rdata_man;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; auto_mem = 1'b1; gnt_man = 1'b0; rvalid_man = 1'b0;
    rdata_man = '0; bus.i_B_J_result = 1'b0; bus.i_target = '0;
    bus.i_id_ready = 1'b1;

    // reset state
    tick(); tick();
    chk("rst_req",   {31'b0, bus.o_imem_req}, 32'd0);
    chk("rst_valid", {31'b0, bus.o_if_valid}, 32'd0);
    chk("rst_mis",   {31'b0, bus.o_if_misaligned}, 32'd0);

    // release: boot fetch stream 0,4,8
    rst_n = 1'b1;
    #1;
    chk("boot_req",  {31'b0, bus.o_imem_req}, 32'd1);
    chk("boot_addr", bus.o_imem_addr, 32'h0);
    tick();
    chk("wait_req",  {31'b0, bus.o_imem_req}, 32'd0);
    tick();
    chk("seq0_valid", {31'b0, bus.o_if_valid}, 32'd1);
    chk("seq0_pc",    bus.o_if_pc, 32'h0);
    chk("seq0_instr", bus.o_if_instr, 32'hA5A5_0000);
    tick();
    chk("seq_gap_valid", {31'b0, bus.o_if_valid}, 32'd0);
    tick();
    chk("seq1_pc", bus.o_if_pc, 32'h4);
    tick(); tick();
    chk("seq2_valid", {31'b0, bus.o_if_valid}, 32'd1);
    chk("seq2_pc",    bus.o_if_pc, 32'h8);

    // decode stalled 10 cycles: FIFO fills with 8,C and requests stop
    bus.i_id_ready = 1'b0;
    tick();
    chk("stall_wait_req", {31'b0, bus.o_imem_req}, 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("full_req", {31'b0, bus.o_imem_req}, 32'd0);
    end
    chk("full_valid", {31'b0, bus.o_if_valid}, 32'd1);
    chk("full_pc",    bus.o_if_pc, 32'h8);
    chk("full_instr", bus.o_if_instr, 32'hA5A5_0008);
    bus.i_id_ready = 1'b1;
    tick();
    chk("drain_pc",   bus.o_if_pc, 32'hC);
    chk("drain_req",  {31'b0, bus.o_imem_req}, 32'd1);
    chk("drain_addr", bus.o_imem_addr, 32'h10);
    tick();
    chk("drain_empty", {31'b0, bus.o_if_valid}, 32'd0);
    tick();
    chk("resume_pc", bus.o_if_pc, 32'h10);

    // redirect while WAIT, stale rvalid dropped
    auto_mem = 1'b0; bus.i_id_ready = 1'b0;
    tick();
    chk("hold_addr", bus.o_imem_addr, 32'h14);
    gnt_man = 1'b1;
    tick();
    gnt_man = 1'b0; bus.i_B_J_result = 1'b1; bus.i_target = 32'h100;
    tick();
    bus.i_B_J_result = 1'b0;
    chk("rdw_valid", {31'b0, bus.o_if_valid}, 32'd0);
    chk("rdw_req",   {31'b0, bus.o_imem_req}, 32'd0);
    rvalid_man = 1'b1; rdata_man = 32'hDEAD_BEEF;
    tick();
    rvalid_man = 1'b0;
    chk("drop_valid", {31'b0, bus.o_if_valid}, 32'd0);
    chk("drop_req",   {31'b0, bus.o_imem_req}, 32'd1);
    chk("drop_addr",  bus.o_imem_addr, 32'h100);
    gnt_man = 1'b1;
    tick();
    gnt_man = 1'b0; rvalid_man = 1'b1; rdata_man = 32'h1111_0100;
    tick();
    rvalid_man = 1'b0;
    chk("tgt_valid", {31'b0, bus.o_if_valid}, 32'd1);
    chk("tgt_pc",    bus.o_if_pc, 32'h100);
    chk("tgt_instr", bus.o_if_instr, 32'h1111_0100);

    // fill to 2 entries, then redirect + pop in the same cycle
    gnt_man = 1'b1;
    tick();
    gnt_man = 1'b0; rvalid_man = 1'b1; rdata_man = 32'h2222_0104;
    tick();
    rvalid_man = 1'b0;
    chk("two_req", {31'b0, bus.o_imem_req}, 32'd0);
    chk("two_pc",  bus.o_if_pc, 32'h100);
    bus.i_id_ready = 1'b1; bus.i_B_J_result = 1'b1; bus.i_target = 32'h40;
    tick();
    bus.i_B_J_result = 1'b0;
    chk("rpop_valid", {31'b0, bus.o_if_valid}, 32'd0);
    chk("rpop_req",   {31'b0, bus.o_imem_req}, 32'd1);
    chk("rpop_addr",  bus.o_imem_addr, 32'h40);
    tick();
    chk("rpop_still_empty", {31'b0, bus.o_if_valid}, 32'd0);

    // redirect latency with zero-wait memory
    bus.i_B_J_result = 1'b1; bus.i_target = 32'h300;
    tick();
    bus.i_B_J_result = 1'b0;
    chk("lat_req",  {31'b0, bus.o_imem_req}, 32'd1);
    chk("lat_addr", bus.o_imem_addr, 32'h300);
    auto_mem = 1'b1;
    tick();
    chk("lat_wait_valid", {31'b0, bus.o_if_valid}, 32'd0);
    tick();
    chk("lat_valid", {31'b0, bus.o_if_valid}, 32'd1);
    chk("lat_pc",    bus.o_if_pc, 32'h300);
    chk("lat_instr", bus.o_if_instr, 32'hA5A5_0300);

    // redirect with gnt in the same cycle, to the top word: PC wraps to 0
    bus.i_B_J_result = 1'b1; bus.i_target = 32'hFFFF_FFFC;
    tick();
    bus.i_B_J_result = 1'b0;
    chk("rg_valid", {31'b0, bus.o_if_valid}, 32'd0);
    chk("rg_req",   {31'b0, bus.o_imem_req}, 32'd0);
    tick();
    chk("rg_drop_valid", {31'b0, bus.o_if_valid}, 32'd0);
    chk("rg_addr",       bus.o_imem_addr, 32'hFFFF_FFFC);
    tick(); tick();
    chk("wrap_pc",    bus.o_if_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", bus.o_if_instr, 32'h5A5A_FFFC);
    chk("wrap_addr",  bus.o_imem_addr, 32'h0);

    // redirect to a non-word-aligned target
    auto_mem = 1'b0; gnt_man = 1'b0; bus.i_id_ready = 1'b0;
    bus.i_B_J_result = 1'b1; bus.i_target = 32'h102;
    tick();
    bus.i_B_J_result = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_valid", {31'b0, bus.o_if_valid}, 32'd1);
    chk("mis_pc",    bus.o_if_pc, 32'h102);
    chk("mis_instr", bus.o_if_instr, 32'h13);
    chk("mis_flag",  {31'b0, bus.o_if_misaligned}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err_req", {31'b0, bus.o_imem_req}, 32'd0);
    end
    bus.i_B_J_result = 1'b1; bus.i_target = 32'h200;
    tick();
    bus.i_B_J_result = 1'b0;
    chk("err_exit_req",   {31'b0, bus.o_imem_req}, 32'd1);
    chk("err_exit_addr",  bus.o_imem_addr, 32'h200);
    chk("err_exit_valid", {31'b0, bus.o_if_valid}, 32'd0);
`else
    chk("mis_req",   {31'b0, bus.o_imem_req}, 32'd1);
    chk("mis_addr",  bus.o_imem_addr, 32'h100);
    chk("mis_flag",  {31'b0, bus.o_if_misaligned}, 32'd0);
    chk("mis_valid", {31'b0, bus.o_if_valid}, 32'd0);
`endif

    // reset during WAIT, late rvalid ignored
    gnt_man = 1'b1;
    tick();
    gnt_man = 1'b0;
    chk("pre_rst_req", {31'b0, bus.o_imem_req}, 32'd0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_req",   {31'b0, bus.o_imem_req}, 32'd0);
    chk("mid_rst_valid", {31'b0, bus.o_if_valid}, 32'd0);
    rst_n = 1'b1; rvalid_man = 1'b1; rdata_man = 32'hBAD0_BAD0;
    #1;
    chk("rel_req",  {31'b0, bus.o_imem_req}, 32'd1);
    chk("rel_addr", bus.o_imem_addr, 32'h0);
    tick();
    rvalid_man = 1'b0;
    chk("late_valid", {31'b0, bus.o_if_valid}, 32'd0);
    chk("late_addr",  bus.o_imem_addr, 32'h0);
    gnt_man = 1'b1;
    tick();
    gnt_man = 1'b0; rvalid_man = 1'b1; rdata_man = 32'h0000_1234;
    tick();
    rvalid_man = 1'b0;
    chk("post_rst_pc",    bus.o_if_pc, 32'h0);
    chk("post_rst_instr", bus.o_if_instr, 32'h0000_1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
